// File: rtl/ahb_matrix_decoder_param.sv
// ============================================================================
// ahb_matrix_decoder_param
//
// Per-input-stage address decoder for the AHB bus matrix. One input stage is
// routed to one of NUM_PORTS output stages. The target is chosen from
// parameter-defined address regions, a runtime port-enable mask and an
// optional remap alias window. Addresses that hit no enabled region go to an
// integrated default slave. That slave answers NONSEQ/SEQ transfers with a
// two-cycle ERROR response and counts them in a saturating error counter.
//
// Ports
//   HCLK             AHB clock
//   HRESETn          asynchronous active-low reset
//   HREADYS          transfer-done indication of the input stage
//   sel_dec          HSEL from the input stage
//   decode_addr_dec  HADDR[31:10] of the current address phase
//   trans_dec        HTRANS of the current address phase
//   port_en          runtime per-port enable (clear = region unmapped)
//   remap            enables the alias window onto REMAP_PORT
//   err_clr          synchronous clear of err_count
//   active_dec_in    per-output-stage "active" indications
//   readyout_dec     per-port HREADYOUT
//   resp_dec         per-port HRESP, 2 bits per port
//   rdata_dec        per-port HRDATA, 32 bits per port
//   ruser_dec        per-port HRUSER, UW bits per port
//   sel_dec_out      one-hot HSEL towards the output stages
//   active_dec       active indication of the selected output stage
//   HREADYOUTS       HREADY feedback to the input stage
//   HRESPS           response to the input stage
//   HRDATAS          read data to the input stage
//   HRUSERS          read user data to the input stage
//   err_count        saturating count of default-slave ERROR responses
// ============================================================================
module ahb_matrix_decoder_param #(
    parameter int                      NUM_PORTS    = 4,
    parameter int                      UW           = 32,
    parameter logic [22*NUM_PORTS-1:0] REGION_BASE  = {NUM_PORTS{22'h000000}},
    parameter logic [22*NUM_PORTS-1:0] REGION_LIMIT = {NUM_PORTS{22'h000000}},
    parameter int                      REMAP_PORT   = 0,
    parameter logic [21:0]             ALIAS_BASE   = 22'h000000,
    parameter logic [21:0]             ALIAS_LIMIT  = 22'h00003f
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HREADYS,
    input  logic                    sel_dec,
    input  logic [21:0]             decode_addr_dec,
    input  logic [1:0]              trans_dec,
    input  logic [NUM_PORTS-1:0]    port_en,
    input  logic                    remap,
    input  logic                    err_clr,
    input  logic [NUM_PORTS-1:0]    active_dec_in,
    input  logic [NUM_PORTS-1:0]    readyout_dec,
    input  logic [2*NUM_PORTS-1:0]  resp_dec,
    input  logic [32*NUM_PORTS-1:0] rdata_dec,
    input  logic [UW*NUM_PORTS-1:0] ruser_dec,
    output logic [NUM_PORTS-1:0]    sel_dec_out,
    output logic                    active_dec,
    output logic                    HREADYOUTS,
    output logic [1:0]              HRESPS,
    output logic [31:0]             HRDATAS,
    output logic [UW-1:0]           HRUSERS,
    output logic [7:0]              err_count
);

    // Default-slave states
    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Region bounds and alias window are carried on nets so the comparators
    // stay generic even when a bound is zero.
    logic [21:0]          region_base  [NUM_PORTS];
    logic [21:0]          region_limit [NUM_PORTS];
    logic [21:0]          alias_base;
    logic [21:0]          alias_limit;

    logic [NUM_PORTS-1:0] region_sel;
    logic                 region_found;
    logic [NUM_PORTS-1:0] alias_sel;
    logic                 alias_hit;

    // Address-phase selection: one-hot real port, or the default slave
    logic [NUM_PORTS-1:0] addr_sel;
    logic                 addr_dflt;

    // Data-phase selection. dp_sel==0 and dp_dflt==0 encodes "none".
    logic [NUM_PORTS-1:0] dp_sel;
    logic                 dp_dflt;

    logic [1:0]           ds_state;
    logic [1:0]           ds_next;
    logic                 ds_qualify;
    logic                 ds_ready;
    logic [1:0]           ds_resp;

    logic                 mux_ready;
    logic [1:0]           mux_resp;
    logic [31:0]          mux_rdata;
    logic [UW-1:0]        mux_ruser;

    // Unpack the flattened region parameters into per-port bounds.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            region_base[i]  = REGION_BASE[22*i +: 22];
            region_limit[i] = REGION_LIMIT[22*i +: 22];
        end
    end

    assign alias_base  = ALIAS_BASE;
    assign alias_limit = ALIAS_LIMIT;

    // Lowest-index enabled port whose region contains the address wins.
    always_comb begin
        region_sel   = '0;
        region_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!region_found && port_en[i] &&
                (decode_addr_dec >= region_base[i]) &&
                (decode_addr_dec <= region_limit[i])) begin
                region_sel[i] = 1'b1;
                region_found  = 1'b1;
            end
        end
    end

    // One-hot of the remap target port.
    always_comb begin
        alias_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i == REMAP_PORT) begin
                alias_sel[i] = 1'b1;
            end
        end
    end

    // The alias only applies when its target port is itself enabled.
    assign alias_hit = remap &&
                       (decode_addr_dec >= alias_base) &&
                       (decode_addr_dec <= alias_limit) &&
                       (|(port_en & alias_sel));

    // An IDLE address phase keeps pointing at the port that owns the current
    // data phase so HSEL towards the output stage does not toggle during idle.
    always_comb begin
        addr_sel  = '0;
        addr_dflt = 1'b0;
        if ((trans_dec == TRANS_IDLE) && (|dp_sel)) begin
            addr_sel = dp_sel;
        end else if (alias_hit) begin
            addr_sel = alias_sel;
        end else if (region_found) begin
            addr_sel = region_sel;
        end else begin
            addr_dflt = 1'b1;
        end
    end

    assign sel_dec_out = sel_dec ? addr_sel : '0;
    assign active_dec  = addr_dflt ? 1'b1 : (|(addr_sel & active_dec_in));

    // Data-phase owner, advanced whenever the input stage completes a beat.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel  <= '0;
            dp_dflt <= 1'b0;
        end else if (HREADYS) begin
            dp_sel  <= sel_dec ? addr_sel : '0;
            dp_dflt <= sel_dec & addr_dflt;
        end
    end

    // Only active NONSEQ/SEQ transfers to the default slave start an ERROR.
    assign ds_qualify = addr_dflt && sel_dec && HREADYS && trans_dec[1];

    // Default-slave next state: ERR1 is the wait cycle, ERR2 completes the
    // ERROR and can chain straight into another one.
    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: ds_next = ds_qualify ? DS_ERR1 : DS_IDLE;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = ds_qualify ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    assign ds_ready = (ds_state != DS_ERR1);
    assign ds_resp  = (ds_state == DS_IDLE) ? RESP_OKAY : RESP_ERROR;

    // Error counter counts entries into ERR1 and saturates; a clear in the
    // same cycle as an entry wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_count <= 8'h00;
        end else if (err_clr) begin
            err_count <= 8'h00;
        end else if ((ds_next == DS_ERR1) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end

    // AND-OR mux of the slave responses using the one-hot data-phase owner.
    always_comb begin
        mux_ready = 1'b0;
        mux_resp  = '0;
        mux_rdata = '0;
        mux_ruser = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dp_sel[i]) begin
                mux_ready = mux_ready | readyout_dec[i];
                mux_resp  = mux_resp  | resp_dec[2*i +: 2];
                mux_rdata = mux_rdata | rdata_dec[32*i +: 32];
                mux_ruser = mux_ruser | ruser_dec[UW*i +: UW];
            end
        end
    end

    // Response back to the input stage: default slave, real port, or an
    // always-ready OKAY when no data phase is in flight.
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;
        HRDATAS    = '0;
        HRUSERS    = '0;
        if (dp_dflt) begin
            HREADYOUTS = ds_ready;
            HRESPS     = ds_resp;
        end else if (|dp_sel) begin
            HREADYOUTS = mux_ready;
            HRESPS     = mux_resp;
            HRDATAS    = mux_rdata;
            HRUSERS    = mux_ruser;
        end
    end

endmodule

// File: tb/tb_ahb_matrix_decoder_param.sv
// ============================================================================
// tb_ahb_matrix_decoder_param
//
// Directed bench for ahb_matrix_decoder_param with four ports:
//   port0 22'h000400..22'h0007ff, port1 22'h080000..22'h08003f,
//   port2 22'h100000..22'h13ffff, port3 22'h3f0000..22'h3fffff,
//   alias window 22'h000000..22'h00003f remapped to port2.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// ============================================================================
module tb_ahb_matrix_decoder_param;

    localparam int NP = 4;
    localparam int UW = 32;
    localparam logic [22*NP-1:0] BASE  = {22'h3f0000, 22'h100000, 22'h080000, 22'h000400};
    localparam logic [22*NP-1:0] LIMIT = {22'h3fffff, 22'h13ffff, 22'h08003f, 22'h0007ff};

    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_NONSEQ = 2'b10;
    localparam logic [21:0] A_P1     = 22'h080000;   // 0x20000100
    localparam logic [21:0] A_P2     = 22'h120000;
    localparam logic [21:0] A_UNM    = 22'h0C0000;   // 0x30000000

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b1;
    logic              HREADYS = 1'b0;
    logic              sel_dec = 1'b0;
    logic [21:0]       decode_addr_dec = '0;
    logic [1:0]        trans_dec = T_IDLE;
    logic [NP-1:0]     port_en = 4'b1111;
    logic              remap = 1'b0;
    logic              err_clr = 1'b0;
    logic [NP-1:0]     active_dec_in = 4'b1010;
    logic [NP-1:0]     readyout_dec = 4'b1111;
    logic [2*NP-1:0]   resp_dec = '0;
    logic [32*NP-1:0]  rdata_dec = {32'h33333333, 32'h22222222, 32'hA5A5A5A5, 32'h11111111};
    logic [UW*NP-1:0]  ruser_dec = {32'h0000D003, 32'h0000D002, 32'h0000BEEF, 32'h0000D000};
    logic [NP-1:0]     sel_dec_out;
    logic              active_dec;
    logic              HREADYOUTS;
    logic [1:0]        HRESPS;
    logic [31:0]       HRDATAS;
    logic [UW-1:0]     HRUSERS;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_err = 8'h00;

    ahb_matrix_decoder_param #(
        .NUM_PORTS(NP), .UW(UW), .REGION_BASE(BASE), .REGION_LIMIT(LIMIT),
        .REMAP_PORT(2), .ALIAS_BASE(22'h000000), .ALIAS_LIMIT(22'h00003f)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .port_en(port_en),
        .remap(remap), .err_clr(err_clr), .active_dec_in(active_dec_in),
        .readyout_dec(readyout_dec), .resp_dec(resp_dec), .rdata_dec(rdata_dec),
        .ruser_dec(ruser_dec), .sel_dec_out(sel_dec_out), .active_dec(active_dec),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS),
        .HRUSERS(HRUSERS), .err_count(err_count)
    );

    always #5 HCLK = ~HCLK;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Present one address phase; outputs are given 1 ns to settle.
    task automatic drive(input logic s, input logic [21:0] a, input logic [1:0] t, input logic r);
        sel_dec = s;
        decode_addr_dec = a;
        trans_dec = t;
        HREADYS = r;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        HRESETn = 1'b0;
        #1;
        checks++; if (HREADYOUTS !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", HREADYOUTS); end
        checks++; if (HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL reset_resp: got %b expected 00", HRESPS); end
        checks++; if (HRDATAS !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", HRDATAS); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_errcnt: got %h expected 00", err_count); end
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_port1();
        drive(1'b1, A_P1, T_NONSEQ, 1'b1);
        checks++; if (sel_dec_out !== 4'b0010) begin errors++; $display("[TB] FAIL p1_sel: got %b expected 0010", sel_dec_out); end
        checks++; if (active_dec !== 1'b1) begin errors++; $display("[TB] FAIL p1_active: got %b expected 1", active_dec); end
        tick();
        // Idle address phase to an unmapped address while port1 owns the data phase
        port_en = 4'b1101;
        drive(1'b1, A_UNM, T_IDLE, 1'b1);
        checks++; if (HRDATAS !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL p1_rdata: got %h expected a5a5a5a5", HRDATAS); end
        checks++; if (HRUSERS !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL p1_ruser: got %h expected 0000beef", HRUSERS); end
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL p1_okay: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
        checks++; if (sel_dec_out !== 4'b0010) begin errors++; $display("[TB] FAIL idle_hold_sel: got %b expected 0010", sel_dec_out); end
        tick();
        // port1 now disabled: the new address phase decodes to the default slave
        drive(1'b1, A_P1, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL p1_disabled_sel: got %b expected 0000", sel_dec_out); end
        checks++; if (HRDATAS !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL p1_dataphase_kept: got %h expected a5a5a5a5", HRDATAS); end
        port_en = 4'b1111;
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        tick();
        checks++; if (HRDATAS !== 32'h0) begin errors++; $display("[TB] FAIL none_rdata: got %h expected 0", HRDATAS); end
    endtask

    task automatic test_port2();
        drive(1'b1, A_P2, T_NONSEQ, 1'b1);
        checks++; if (sel_dec_out !== 4'b0100) begin errors++; $display("[TB] FAIL p2_sel: got %b expected 0100", sel_dec_out); end
        checks++; if (active_dec !== 1'b0) begin errors++; $display("[TB] FAIL p2_active: got %b expected 0", active_dec); end
        tick();
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        checks++; if (HRDATAS !== 32'h22222222) begin errors++; $display("[TB] FAIL p2_rdata: got %h expected 22222222", HRDATAS); end
        tick();
    endtask

    task automatic test_boundaries();
        drive(1'b1, 22'h08003f, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0010) begin errors++; $display("[TB] FAIL p1_limit: got %b expected 0010", sel_dec_out); end
        drive(1'b1, 22'h080040, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL p1_above_limit: got %b expected 0000", sel_dec_out); end
        drive(1'b1, 22'h000400, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0001) begin errors++; $display("[TB] FAIL p0_base: got %b expected 0001", sel_dec_out); end
        drive(1'b1, 22'h000000, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL noremap_zero: got %b expected 0000", sel_dec_out); end
        drive(1'b0, A_P2, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL sel_gate: got %b expected 0000", sel_dec_out); end
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        tick();
    endtask

    task automatic test_unmapped();
        drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL unm_sel: got %b expected 0000", sel_dec_out); end
        checks++; if (active_dec !== 1'b1) begin errors++; $display("[TB] FAIL unm_active: got %b expected 1", active_dec); end
        tick();
        exp_err = exp_err + 8'd1;
        drive(1'b0, 22'h0, T_IDLE, 1'b0);
        checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin errors++; $display("[TB] FAIL unm_err1: got %b/%b expected 0/01", HREADYOUTS, HRESPS); end
        checks++; if (err_count !== exp_err) begin errors++; $display("[TB] FAIL unm_errcnt: got %h expected %h", err_count, exp_err); end
        tick();
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin errors++; $display("[TB] FAIL unm_err2: got %b/%b expected 1/01", HREADYOUTS, HRESPS); end
        checks++; if (HRDATAS !== 32'h0) begin errors++; $display("[TB] FAIL unm_rdata: got %h expected 0", HRDATAS); end
        tick();
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL unm_back_idle: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
        // IDLE transfer to the default slave is a zero-wait OKAY
        drive(1'b1, A_UNM, T_IDLE, 1'b1);
        tick();
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL dflt_idle_okay: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
        checks++; if (err_count !== exp_err) begin errors++; $display("[TB] FAIL dflt_idle_errcnt: got %h expected %h", err_count, exp_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_err = exp_err + 8'd1;
            drive(1'b1, A_UNM, T_NONSEQ, 1'b0);
            checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin errors++; $display("[TB] FAIL b2b_err1_%0d: got %b/%b expected 0/01", k, HREADYOUTS, HRESPS); end
            checks++; if (err_count !== exp_err) begin errors++; $display("[TB] FAIL b2b_errcnt_%0d: got %h expected %h", k, err_count, exp_err); end
            tick();
            if (k < 3) drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
            else       drive(1'b0, 22'h0, T_IDLE, 1'b1);
            checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin errors++; $display("[TB] FAIL b2b_err2_%0d: got %b/%b expected 1/01", k, HREADYOUTS, HRESPS); end
            tick();
        end
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL b2b_idle: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
    endtask

    task automatic test_remap();
        remap = 1'b1;
        drive(1'b1, 22'h000000, T_NONSEQ, 1'b1);
        checks++; if (sel_dec_out !== 4'b0100) begin errors++; $display("[TB] FAIL remap_sel: got %b expected 0100", sel_dec_out); end
        tick();
        drive(1'b1, 22'h00003f, T_NONSEQ, 1'b0);
        checks++; if (HRDATAS !== 32'h22222222) begin errors++; $display("[TB] FAIL remap_rdata: got %h expected 22222222", HRDATAS); end
        checks++; if (sel_dec_out !== 4'b0100) begin errors++; $display("[TB] FAIL remap_limit: got %b expected 0100", sel_dec_out); end
        drive(1'b1, 22'h000040, T_NONSEQ, 1'b0);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL remap_above: got %b expected 0000", sel_dec_out); end
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        tick();
        port_en = 4'b1011;
        drive(1'b1, 22'h000000, T_NONSEQ, 1'b1);
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL remap_dis_sel: got %b expected 0000", sel_dec_out); end
        tick();
        exp_err = exp_err + 8'd1;
        drive(1'b0, 22'h0, T_IDLE, 1'b0);
        checks++; if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin errors++; $display("[TB] FAIL remap_dis_err1: got %b/%b expected 0/01", HREADYOUTS, HRESPS); end
        tick();
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin errors++; $display("[TB] FAIL remap_dis_err2: got %b/%b expected 1/01", HREADYOUTS, HRESPS); end
        tick();
        checks++; if (err_count !== exp_err) begin errors++; $display("[TB] FAIL remap_errcnt: got %h expected %h", err_count, exp_err); end
        remap = 1'b0;
        port_en = 4'b1111;
    endtask

    task automatic test_saturation();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err = 8'h00;
        #1;
        checks++; if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL clr_errcnt: got %h expected 00", err_count); end
        drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
        tick();
        for (int k = 1; k < 256; k++) begin
            drive(1'b1, A_UNM, T_NONSEQ, 1'b0);
            tick();
            drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
            tick();
        end
        checks++; if (err_count !== 8'hFF) begin errors++; $display("[TB] FAIL sat_errcnt: got %h expected ff", err_count); end
        drive(1'b1, A_UNM, T_NONSEQ, 1'b0);
        tick();
        // New error accepted in ERR2 together with a clear
        err_clr = 1'b1;
        drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
        tick();
        err_clr = 1'b0;
        drive(1'b0, 22'h0, T_IDLE, 1'b0);
        checks++; if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL clr_vs_inc: got %h expected 00", err_count); end
        checks++; if (HREADYOUTS !== 1'b0) begin errors++; $display("[TB] FAIL clr_vs_inc_err1: got %b expected 0", HREADYOUTS); end
        tick();
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        tick();
        exp_err = 8'h00;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, A_UNM, T_NONSEQ, 1'b1);
        tick();
        drive(1'b1, A_UNM, T_NONSEQ, 1'b0);
        checks++; if (HREADYOUTS !== 1'b0 || err_count !== 8'h01) begin errors++; $display("[TB] FAIL mid_pre: got %b/%h expected 0/01", HREADYOUTS, err_count); end
        HRESETn = 1'b0;
        #1;
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_resp: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_errcnt: got %h expected 00", err_count); end
        checks++; if (sel_dec_out !== 4'b0000) begin errors++; $display("[TB] FAIL mid_rst_sel: got %b expected 0000", sel_dec_out); end
        tick();
        tick();
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || err_count !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_held: got %b/%b/%h expected 1/00/00", HREADYOUTS, HRESPS, err_count); end
        HRESETn = 1'b1;
        drive(1'b0, 22'h0, T_IDLE, 1'b1);
        tick();
        checks++; if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("[TB] FAIL mid_after: got %b/%b expected 1/00", HREADYOUTS, HRESPS); end
    endtask

    initial begin
        #2;
        test_reset();
        test_port1();
        test_port2();
        test_boundaries();
        test_unmapped();
        test_back_to_back();
        test_remap();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_matrix_decoder_param.md
Name: ahb_matrix_decoder_param

Overview:
- Parametrised successor of the bus-matrix per-input decoder.
- Routes one AHB input stage to any of NUM_PORTS output stages using parameter-defined address regions, a runtime port-enable mask and an optional remap alias.
- Contains an integrated default slave that gives a two-cycle ERROR response, plus a saturating counter of unmapped-access errors.
- Sits between each bus-matrix input stage and the output-stage arbiters.

Parameters:
- NUM_PORTS, 4, number of output ports (1..8).
- UW, 32, HRUSER width.
- REGION_BASE, {NUM_PORTS{22'h000000}}, flattened per-port lower bound of HADDR[31:10]; port i uses bits [22*i+:22].
- REGION_LIMIT, {NUM_PORTS{22'h000000}}, flattened per-port inclusive upper bound of HADDR[31:10].
- REMAP_PORT, 0, port index that receives the alias window when remap=1.
- ALIAS_BASE, 22'h000000, alias window lower bound, HADDR[31:10].
- ALIAS_LIMIT, 22'h00003f, alias window inclusive upper bound.

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  asynchronous active-low reset.
- HREADYS  in  1  transfer done on input stage.
- sel_dec  in  1  HSEL from input stage.
- decode_addr_dec  in  22  HADDR[31:10].
- trans_dec  in  2  HTRANS.
- port_en  in  NUM_PORTS  runtime per-port enable; bit clear = region unmapped.
- remap  in  1  enables the alias window.
- err_clr  in  1  synchronous clear of err_count.
- active_dec_in  in  NUM_PORTS  per-output-stage active.
- readyout_dec  in  NUM_PORTS  per-port HREADYOUT.
- resp_dec  in  2*NUM_PORTS  per-port HRESP.
- rdata_dec  in  32*NUM_PORTS  per-port HRDATA.
- ruser_dec  in  UW*NUM_PORTS  per-port HRUSER.
- sel_dec_out  out  NUM_PORTS  one-hot HSEL to output stages.
- active_dec  out  1  selected active.
- HREADYOUTS  out  1  HREADY feedback.
- HRESPS  out  2  response.
- HRDATAS  out  32  read data.
- HRUSERS  out  UW  read user data.
- err_count  out  8  saturating count of default-slave ERROR responses.

Behaviour:
- Clock and reset: one clock, HCLK. Reset is asynchronous and active-low on HRESETn.
- Address decode (combinational), in priority order:
  - Alias hit: remap=1, ALIAS_BASE<=addr<=ALIAS_LIMIT, and port_en[REMAP_PORT] set → REMAP_PORT.
  - Otherwise the lowest-index port i with port_en[i] set and base_i<=addr<=limit_i.
  - Otherwise the default slave.
- Hold rule: if trans_dec==IDLE and the registered data-phase port is a real port, the address-phase port equals the data-phase port. This keeps HSEL stable during idle.
- sel_dec_out: one-hot of the address-phase port, gated by sel_dec. It is all-zero when the default slave is selected or sel_dec=0.
- active_dec: the selected active_dec_in bit; 1 for the default slave.
- Data-phase port register:
  - Loaded with the address-phase selection on HCLK rising edge when HREADYS=1.
  - Reset value "none".
  - In "none": HREADYOUTS=1, HRESPS=2'b00, HRDATAS=0, HRUSERS=0.
- Data-phase muxes: HREADYOUTS, HRESPS, HRDATAS and HRUSERS come from the registered port. For the default slave, HRDATAS and HRUSERS are 0, and ready/resp come from the FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE → ERR1 when the default slave is selected, sel_dec=1, HREADYS=1 and trans_dec[1]=1 (NONSEQ/SEQ).
  - ERR1: readyout=0, resp=2'b01; always → ERR2.
  - ERR2: readyout=1, resp=2'b01. → ERR1 if a new qualifying transfer is accepted (HREADYS=1); else → IDLE.
  - IDLE: readyout=1, resp=2'b00.
  - IDLE/BUSY transfers to the default slave: zero-wait OKAY.
- err_count:
  - +1 on each entry to ERR1; saturates at 8'hFF.
  - err_clr has priority over increment; simultaneous clear+increment → 0.
- Reset mid-transfer: all state returns immediately to reset values. Outputs then read HREADYOUTS=1, HRESPS=OKAY, err_count=0, sel_dec_out=0.
- port_en changes take effect on the next address phase only; the registered data phase is unaffected.

Test Plan:
- Setup: NUM_PORTS=4; port1 region 22'h080000..22'h08003f; port2 region 22'h100000..22'h13ffff; all port_en=1.
- NONSEQ to 0x20000100, sel_dec=1, HREADYS=1 → sel_dec_out=4'b0010. Next cycle HRDATAS=rdata_dec port1 (drive 0xA5A5A5A5 → 0xA5A5A5A5).
- NONSEQ to 0x30000000 (unmapped) → sel_dec_out=0. Data phase: HREADYOUTS 0 then 1, HRESPS 01 both cycles, err_count=1.
- Back-to-back unmapped NONSEQs accepted in ERR2 → ERR1/ERR2 repeat with no IDLE gap. err_count increments per transfer.
- remap=1, REMAP_PORT=2, NONSEQ to 0x00000000 → sel_dec_out=4'b0100. With port_en[2]=0 → default slave ERROR.
- Saturation: force 256 errors → err_count=8'hFF. err_clr together with a new error → 0.
- Assert HRESETn low during ERR1 → HREADYOUTS=1, HRESPS=00, err_count=0 while reset is held.
